// File: rtl/transport_sched_pkg.sv
// Shared types and constants for the transport scheduler slice.
package transport_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [DATA_W-1:0] data_t;

    // Next requester index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        if (idx + 32'sd1 >= n) begin
            return 32'sd0;
        end else begin
            return idx + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/transport_sched_if.sv
// Byte stream from the scheduler (master) to the transport sink (slave).
interface transport_sched_if #(
    parameter int ID_W = 2
);
    import transport_pkg::*;

    logic            out_valid;
    logic            out_ready;
    data_t           out_data;
    logic            out_last;
    logic [ID_W-1:0] out_id;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        output out_id,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        input  out_id,
        output out_ready
    );

endinterface

// File: rtl/transport_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// scanning upward with wrap.
module rr_arbiter
    import transport_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    int scan_idx_s;

    // Walk NUM_REQ candidates starting at ptr; the first hit wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        scan_idx_s = int'(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && req[scan_idx_s]) begin
                gnt_any                = 1'b1;
                gnt_onehot[scan_idx_s] = 1'b1;
                gnt_idx                = ID_W'(scan_idx_s);
            end else begin
                gnt_any = gnt_any;
            end
            scan_idx_s = wrap_inc(scan_idx_s, NUM_REQ);
        end
    end

endmodule

// File: rtl/transport_sched.sv
// Round-robin transport scheduler: one burst of req_len incrementing bytes
// per grant on a valid/ready stream.
// Optional stall timeout: define TRANSPORT_SCHED_TIMEOUT_EN.
module transport_sched
    import transport_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_seed,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    transport_sched_if.master         strm,
    output logic                      abort
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("transport_sched: NUM_REQ must be 2..8");
    end
    if ((2 ** ID_W) < NUM_REQ) begin : g_bad_id_w
        $error("transport_sched: ID_W too narrow for NUM_REQ");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("transport_sched: TIMEOUT_CYC must be at least 1");
    end

    state_e              state_q,  state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q,     id_d;
    logic [NUM_REQ-1:0]  grant_q,  grant_d;
    logic [NUM_REQ-1:0]  done_q,   done_d;
    len_t                rem_q,    rem_d;
    data_t               data_q,   data_d;
    logic                valid_q,  valid_d;
    logic                last_q,   last_d;
    logic                busy_q,   busy_d;

    logic [NUM_REQ-1:0]  arb_onehot_s;
    logic [ID_W-1:0]     arb_idx_s;
    logic                arb_any_s;
    len_t                win_len_s;
    data_t               win_seed_s;

`ifdef TRANSPORT_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                abort_q, abort_d;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req),
        .ptr        (rr_ptr_q),
        .gnt_onehot (arb_onehot_s),
        .gnt_idx    (arb_idx_s),
        .gnt_any    (arb_any_s)
    );

    assign win_len_s  = req_len[int'(arb_idx_s)*LEN_W +: LEN_W];
    assign win_seed_s = req_seed[int'(arb_idx_s)*DATA_W +: DATA_W];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        grant_d  = grant_q;
        done_d   = '0;
        rem_d    = rem_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
`ifdef TRANSPORT_SCHED_TIMEOUT_EN
        stall_d  = stall_q;
        abort_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
`ifdef TRANSPORT_SCHED_TIMEOUT_EN
                stall_d = '0;
`endif
                if (arb_any_s) begin
                    rr_ptr_d = ID_W'(wrap_inc(int'(arb_idx_s), NUM_REQ));
                    id_d     = arb_idx_s;
                    busy_d   = 1'b1;
                    if (win_len_s != 8'd0) begin
                        state_d = BURST;
                        grant_d = arb_onehot_s;
                        valid_d = 1'b1;
                        data_d  = win_seed_s;
                        rem_d   = win_len_s;
                        last_d  = (win_len_s == 8'd1);
                    end else begin
                        // Zero-length request completes without any bytes.
                        state_d = DONE;
                        done_d  = arb_onehot_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (valid_q && strm.out_ready) begin
`ifdef TRANSPORT_SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (rem_q > 8'd1) begin
                        data_d = data_q + 8'd1;
                        rem_d  = rem_q - 8'd1;
                        last_d = (rem_q == 8'd2);
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        grant_d = '0;
                        done_d  = grant_q;
                        rem_d   = 8'd0;
                    end
                end else begin
`ifdef TRANSPORT_SCHED_TIMEOUT_EN
                    // The edge closing the TIMEOUT_CYC-th stalled cycle aborts.
                    if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
                        state_d = DONE;
                        abort_d = 1'b1;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        grant_d = '0;
                        done_d  = grant_q;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
`else
                    state_d = BURST;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset truncates any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            rem_q    <= 8'd0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

`ifdef TRANSPORT_SCHED_TIMEOUT_EN
    // Stall counter and abort pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    assign grant          = grant_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign strm.out_valid = valid_q;
    assign strm.out_data  = data_q;
    assign strm.out_last  = last_q;
    assign strm.out_id    = id_q;

endmodule
